// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - hazard, forwarding and memory-wait sequencing for a 5-stage RV32I pipeline
//
// Ports:
//   CLK, RST                  clock (rising edge), asynchronous active-high reset
//   Rs1D/Rs2D, Rs1E/Rs2E      source register indices in D and E
//   RdE/RdM/RdW               destination register indices in E/M/W
//   RegWriteM/RegWriteW       destination write enables in M/W
//   ResultSrcE                E-stage result select (2'b01 = load)
//   PCSrcE                    branch taken / jump in E
//   MemReqM/MemReadyM         M-stage memory request and acknowledge
//   StallF/D/E/M              hold PC, IF-ID, ID-EX, EX-MEM
//   FlushD/E/W                bubble into IF-ID, ID-EX, MEM-WB
//   ForwardAE/ForwardBE       00 regfile, 01 from W, 10 from M
//   MemTimeout                sticky memory wait fault
// Optional (HAZARD_PERF_CNT_EN): LwStallCnt, FlushCnt, MemWaitCnt saturating counters.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 15
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic [1:0]            ResultSrcE,
  input  logic                  PCSrcE,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  MemTimeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      LwStallCnt,
  output logic [CNT_W-1:0]      FlushCnt,
  output logic [CNT_W-1:0]      MemWaitCnt
`endif
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_VAL = CW'(MEM_TIMEOUT);
  localparam bit TMO_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_FAULT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          lw_stall;
  logic          mem_stall;

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // In WAIT the pipeline is released in the same cycle ready arrives, so the
  // WAIT term is qualified by !MemReadyM; FAULT freezes unconditionally.
  assign mem_stall = (MemReqM && !MemReadyM) ||
                     ((state == S_WAIT) && !MemReadyM) ||
                     (state == S_FAULT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_nx = S_WAIT;
          cnt_nx   = CW'(1);
        end
      end
      S_WAIT: begin
        if (MemReadyM) begin
          state_nx = S_RUN;
          cnt_nx   = '0;
        end else if (TMO_EN && (cnt == TMO_VAL)) begin
          state_nx = S_FAULT;
        end else if (cnt != '1) begin
          // Saturate rather than wrap when the timeout is disabled.
          cnt_nx = cnt + CW'(1);
        end
      end
      S_FAULT: begin
        state_nx = S_FAULT;
      end
      default: begin
        state_nx = S_RUN;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushW     = 1'b0;
    ForwardAE  = 2'b00;
    ForwardBE  = 2'b00;
    MemTimeout = (state == S_FAULT);
    if (RST) begin
      FlushD     = 1'b1;
      FlushE     = 1'b1;
      FlushW     = 1'b1;
      MemTimeout = 1'b0;
    end else begin
      if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;
      if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;

      if (mem_stall) begin
        // E is held, so redirect and load-use are re-evaluated on release.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall || PCSrcE;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LwStallCnt <= '0;
      FlushCnt   <= '0;
      MemWaitCnt <= '0;
    end else begin
      if (!mem_stall && lw_stall && (LwStallCnt != '1)) LwStallCnt <= LwStallCnt + CNT_W'(1);
      if (!mem_stall && PCSrcE && (FlushCnt != '1))     FlushCnt   <= FlushCnt + CNT_W'(1);
      if (mem_stall && (MemWaitCnt != '1))              MemWaitCnt <= MemWaitCnt + CNT_W'(1);
    end
  end
`endif

endmodule
